// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-read-port register file.
package regfile_pkg;

  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned DEF_NUM_REGS = 32;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int unsigned DEF_ADDR_W = addr_w(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     en;
    reg_idx_t addr;
  } rd_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits; a reservation beats a same-cycle writeback clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] busy_next
);

  logic [NUM_REGS-1:0] busy_q;

  always_comb begin
    busy_next = busy_q;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: registered write-first reads on NUM_RD ports.
// Busy scoreboard present only when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != ZeroIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_next;
  logic                rd_busy_q [NUM_RD];

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (rsv_en),
    .set_addr  (rsv_addr),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .busy      (busy_vec),
    .busy_next (busy_next)
  );
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_en, rsv_addr};
  assign busy_vec   = '0;
  assign rd_busy    = '0;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Write-first: forward this edge's writeback data to a matching read.
    always_comb begin
      data_d = regs_q[addr];
      if (wr_hit && (wr_addr == addr)) data_d = wr_data;
      if (addr == ZeroIdx) data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rd_data_q[k] <= '0;
      else if (rd_en[k]) rd_data_q[k] <= data_d;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_data_q[k];

`ifdef REGFILE_SCOREBOARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rd_busy_q[k] <= 1'b0;
      else if (rd_en[k]) rd_busy_q[k] <= busy_next[addr];
    end

    assign rd_busy[k] = rd_busy_q[k];
`endif
  end

endmodule
